// File: rtl/ser_tx_arbiter.sv
// ser_tx_arbiter: round-robin scheduler sharing one parallel-to-serial shifter.
// Each requester offers a word plus a bit count. One request is granted at a
// time and its lowest m bits are shifted out MSB-first on a single line.
//
// Ports:
//   clk_i           - clock, all logic on the rising edge
//   rst_i           - synchronous active-high reset
//   req_val_i       - per-requester request valid
//   req_data_i      - flattened words, requester k at [k*DATA_W +: DATA_W]
//   req_mod_i       - flattened bit counts, requester k at [k*MOD_W +: MOD_W]
//   req_ack_o       - one-hot combinational accept, high in the grant cycle
//   ser_data_o      - serial data, 0 while not shifting
//   ser_data_val_o  - serial data valid
//   ser_src_o       - index of the requester whose word is being shifted
//   busy_o          - high while a word is being shifted
module ser_tx_arbiter #(
  parameter int unsigned REQ_CNT = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MOD_W   = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [REQ_CNT-1:0]         req_val_i,
  input  logic [REQ_CNT*DATA_W-1:0]  req_data_i,
  input  logic [REQ_CNT*MOD_W-1:0]   req_mod_i,
  output logic [REQ_CNT-1:0]         req_ack_o,
  output logic                       ser_data_o,
  output logic                       ser_data_val_o,
  output logic [$clog2(REQ_CNT)-1:0] ser_src_o,
  output logic                       busy_o
);

  localparam int unsigned IDX_W    = $clog2(REQ_CNT);
  localparam int unsigned CNT_W    = $clog2(DATA_W + 1);
  localparam int unsigned MIN_BITS = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;

  logic                found;
  logic [IDX_W-1:0]    win;
  logic [IDX_W:0]      idx_sum;
  logic [DATA_W-1:0]   sel_data;
  logic [MOD_W-1:0]    sel_mod;
  logic [CNT_W-1:0]    eff_cnt;
  logic                window;
  logic                grant;

  // Round-robin search: first valid requester starting at ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx_sum = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      idx_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (idx_sum >= (IDX_W+1)'(REQ_CNT)) begin
        idx_sum = idx_sum - (IDX_W+1)'(REQ_CNT);
      end
      if (!found && req_val_i[idx_sum[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = idx_sum[IDX_W-1:0];
      end
    end
  end

  // Winner's payload and clamped bit count.
  always_comb begin
    sel_data = req_data_i[win*DATA_W +: DATA_W];
    sel_mod  = req_mod_i[win*MOD_W +: MOD_W];
    if (32'(sel_mod) > DATA_W) begin
      eff_cnt = CNT_W'(DATA_W);
    end else begin
      eff_cnt = CNT_W'(sel_mod);
    end
  end

  // A new word may be accepted when idle or while the last bit is on the line.
  assign window = (state_q == IDLE) || (cnt_q == CNT_W'(1));
  assign grant  = window && found && !rst_i;

  // Next-state logic: shift while working, then overlay any grant.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;

    if (state_q == WORK) begin
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        sh_d    = '0;
        cnt_d   = '0;
      end
    end

    if (grant) begin
      ptr_d = (win == IDX_W'(REQ_CNT - 1)) ? '0 : win + IDX_W'(1);
      if (32'(eff_cnt) >= MIN_BITS) begin
        // Left-align the lowest eff_cnt bits so the MSB leads.
        sh_d    = sel_data << (DATA_W - 32'(eff_cnt));
        cnt_d   = eff_cnt;
        src_d   = win;
        state_d = WORK;
      end else begin
        // Undersized: accepted and dropped.
        sh_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  assign req_ack_o      = grant ? (REQ_CNT'(1) << win) : '0;
  assign ser_data_val_o = (state_q == WORK);
  assign busy_o         = (state_q == WORK);
  assign ser_data_o     = (state_q == WORK) && sh_q[DATA_W-1];
  assign ser_src_o      = src_q;

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// tb_ser_tx_arbiter: self-checking bench for ser_tx_arbiter.
// A queue-of-pending-bits reference model checks every cycle; directed
// sequences and a transaction table cover the listed corner cases.
module tb_ser_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    val;
  logic [N*DW-1:0] data;
  logic [N*MW-1:0] mod;
  logic [N-1:0]    ack;
  logic            sd;
  logic            sv;
  logic [1:0]      src;
  logic            busy;

  always #5 clk = ~clk;

  ser_tx_arbiter #(.REQ_CNT(N), .DATA_W(DW), .MOD_W(MW)) dut (
    .clk_i(clk), .rst_i(rst), .req_val_i(val), .req_data_i(data),
    .req_mod_i(mod), .req_ack_o(ack), .ser_data_o(sd),
    .ser_data_val_o(sv), .ser_src_o(src), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bits still to appear on the line, pointer, source.
  bit       pq[$];
  int       mptr = 0;
  int       msrc = 0;
  bit       chk_en = 1'b0;
  logic [N-1:0] e_ack = '0;

  logic [N-1:0] obs_ack;
  logic         obs_val, obs_data, obs_busy;
  logic [1:0]   obs_src;

  typedef struct {
    int          k;
    logic [15:0] d;
    int          md;
    logic [15:0] exp;
    int          len;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [15:0] d, input logic [4:0] m);
    val[k]          = v;
    data[k*DW +: DW] = d;
    mod[k*MW +: MW]  = m;
  endtask

  // Sample at negedge+1, check against model, advance model, go to next negedge.
  task automatic cycle();
    int          k;
    int          m;
    int          j;
    logic [15:0] d;
    #1;
    obs_ack  = ack;
    obs_val  = sv;
    obs_data = sd;
    obs_src  = src;
    obs_busy = busy;

    k = -1;
    if (!rst && pq.size() <= 1) begin
      for (int i = 0; i < N; i++) begin
        j = (mptr + i) % N;
        if (k < 0 && val[j]) k = j;
      end
    end
    e_ack = '0;
    if (k >= 0) e_ack[k] = 1'b1;

    check("ack", int'(ack), int'(e_ack));
    if (chk_en) begin
      check("ser_val", int'(sv), (pq.size() > 0) ? 1 : 0);
      check("ser_data", int'(sd), (pq.size() > 0) ? int'(pq[0]) : 0);
      check("ser_src", int'(src), msrc);
      check("busy", int'(busy), (pq.size() > 0) ? 1 : 0);
    end

    if (rst) begin
      pq.delete();
      mptr   = 0;
      msrc   = 0;
      chk_en = 1'b1;
    end else begin
      if (pq.size() > 0) void'(pq.pop_front());
      if (k >= 0) begin
        mptr = (k + 1) % N;
        m    = int'(mod[k*MW +: MW]);
        if (m > DW) m = DW;
        if (m >= 3) begin
          d = data[k*DW +: DW];
          for (int b = m - 1; b >= 0; b--) pq.push_back(d[b]);
          msrc = k;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[8];
    int          n;
    logic [15:0] w;
    logic [3:0]  w4;
    int          cnt;

    tbl[0] = '{0, 16'hA5C3, 16, 16'hA5C3, 16};
    tbl[1] = '{2, 16'hFFFF, 20, 16'hFFFF, 16};
    tbl[2] = '{2, 16'h0013,  5, 16'h0013,  5};
    tbl[3] = '{3, 16'hF0F0,  8, 16'h00F0,  8};
    tbl[4] = '{1, 16'h0005,  3, 16'h0005,  3};
    tbl[5] = '{1, 16'h1234,  0, 16'h0000,  0};
    tbl[6] = '{0, 16'h8001, 31, 16'h8001, 16};
    tbl[7] = '{3, 16'hFFFF,  2, 16'h0000,  0};

    // Reset with every requester valid.
    rst = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 16'(16'h1000 * (k + 1) + 16'h9), 5'd4);
    for (int c = 0; c < 2; c++) begin
      cycle();
      check("reset_ack", int'(obs_ack), 0);
    end
    check("reset_val", int'(obs_val), 0);
    check("reset_data", int'(obs_data), 0);
    check("reset_src", int'(obs_src), 0);
    check("reset_busy", int'(obs_busy), 0);

    // Round-robin back-to-back with all four held valid, mod 4.
    rst = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      cycle();
      if (c % 4 == 0) check("rr_grant", int'(obs_ack), 1 << ((c / 4) % 4));
      else            check("rr_noack", int'(obs_ack), 0);
      if (c >= 1) begin
        check("rr_val", int'(obs_val), 1);
        check("rr_src", int'(obs_src), ((c - 1) / 4) % 4);
      end
    end
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 16'h0, 5'd0);
    for (int c = 0; c < 6; c++) cycle();
    check("rr_drain", int'(obs_val), 0);

    // Undersized request at ptr=1 followed by a 4-bit request.
    set_req(1, 1'b1, 16'h1234, 5'd2);
    set_req(2, 1'b1, 16'h000A, 5'd4);
    cycle();
    check("us_ack1", int'(obs_ack), 4'b0010);
    set_req(1, 1'b0, 16'h0, 5'd0);
    cycle();
    check("us_ack2", int'(obs_ack), 4'b0100);
    check("us_noout", int'(obs_val), 0);
    set_req(2, 1'b0, 16'h0, 5'd0);
    w4 = '0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("us_val", int'(obs_val), 1);
      w4 = {w4[2:0], obs_data};
    end
    check("us_bits", int'(w4), 4'hA);
    cycle();
    check("us_end", int'(obs_val), 0);

    // Single-word transaction table.
    foreach (tbl[t]) begin
      set_req(tbl[t].k, 1'b1, tbl[t].d, 5'(tbl[t].md));
      cycle();
      check("tbl_ack", int'(obs_ack), 1 << tbl[t].k);
      set_req(tbl[t].k, 1'b0, 16'h0, 5'd0);
      n = 0;
      w = '0;
      for (int c = 0; c < 20; c++) begin
        cycle();
        if (obs_val) begin
          w = {w[14:0], obs_data};
          n++;
          check("tbl_src", int'(obs_src), tbl[t].k);
        end
      end
      check("tbl_len", n, tbl[t].len);
      check("tbl_bits", int'(w), int'(tbl[t].exp));
    end

    // Reset after three bits of a 16-bit word.
    set_req(0, 1'b1, 16'hA5C3, 5'd16);
    cycle();
    set_req(0, 1'b0, 16'h0, 5'd0);
    for (int c = 0; c < 3; c++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("mid_val", int'(obs_val), 0);
    check("mid_data", int'(obs_data), 0);
    check("mid_busy", int'(obs_busy), 0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (obs_val) cnt++;
    end
    check("mid_resume", cnt, 0);

    // Randomized requesters obeying the hold-until-ack handshake.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (val[k] && e_ack[k]) begin
          if ($urandom % 2 == 0) set_req(k, 1'b0, 16'h0, 5'd0);
          else set_req(k, 1'b1, 16'($urandom), 5'($urandom_range(0, 31)));
        end else if (!val[k] && ($urandom % 3 == 0)) begin
          set_req(k, 1'b1, 16'($urandom), 5'($urandom_range(0, 20)));
        end
      end
      rst = ($urandom % 300 == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
